// File: rtl/conv_row_sequencer.sv
// Row sequencer for the convolution bank: walks rowNumber over every output
// row, pulses conv_start once per row, captures each finished row into a
// registered feature map and pulses done after the last row is stored.
module conv_row_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  output logic [5:0]                                  rowNumber,
  output logic                                        conv_start,
  input  logic                                        conv_done,
  input  logic [(W-F+1)*DATA_WIDTH-1:0]               conv_row,
  output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]       featureMap,
  output logic                                        busy,
  output logic                                        done
);

  localparam int ROWS     = H - F + 1;
  localparam int COLS     = W - F + 1;
  localparam int ROW_BITS = COLS * DATA_WIDTH;
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;
  logic   capture;

  // A row result is accepted only while waiting on the convolution units
  assign capture = (state == WAIT) && conv_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_next = state;
    conv_start = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        conv_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
          state_next = (rowNumber == LAST_ROW) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Row index: cleared on a new pass, advanced after each non-final capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rowNumber <= '0;
    end else if ((state == IDLE) && start) begin
      rowNumber <= '0;
    end else if (capture && (rowNumber != LAST_ROW)) begin
      rowNumber <= rowNumber + 6'd1;
    end
  end

  // Feature map: only the current row's slice is written on a capture
  always_ff @(posedge clk) begin
    if (reset) begin
      featureMap <= '0;
    end else if (capture) begin
      featureMap[int'(rowNumber)*ROW_BITS +: ROW_BITS] <= conv_row;
    end
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Self-checking bench for conv_row_sequencer: a behavioural convolution-unit
// model answers each conv_start after a per-row latency, and each pass is
// checked against the cycle timeline and data derived arithmetically.
module tb_conv_row_sequencer;

  localparam int DW   = 32;
  localparam int HH   = 32;
  localparam int WW   = 32;
  localparam int FF   = 5;
  localparam int ROWS = HH - FF + 1;
  localparam int COLS = WW - FF + 1;

  logic                        clk;
  logic                        reset;
  logic                        start;
  logic [5:0]                  rowNumber;
  logic                        conv_start;
  logic                        conv_done;
  logic [COLS*DW-1:0]          conv_row;
  logic [ROWS*COLS*DW-1:0]     featureMap;
  logic                        busy;
  logic                        done;

  conv_row_sequencer #(
    .DATA_WIDTH(DW),
    .H(HH),
    .W(WW),
    .F(FF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rowNumber(rowNumber),
    .conv_start(conv_start),
    .conv_done(conv_done),
    .conv_row(conv_row),
    .featureMap(featureMap),
    .busy(busy),
    .done(done)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  logic [DW-1:0] gen     [ROWS][COLS];
  logic [DW-1:0] exp_map [ROWS][COLS];
  int            lat_tab [ROWS];
  int            unit_row;
  int            cs_q[$];
  int            row_q[$];
  int            done_q[$];
  int            busy_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log pulses and busy cycles, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        cs_q.push_back(cyc);
        row_q.push_back(int'(rowNumber));
      end
      if (done === 1'b1) done_q.push_back(cyc);
      if (busy === 1'b1) busy_cnt++;
    end
  end

  // Convolution-unit model: result valid lat_tab[row] cycles after conv_start
  initial begin
    int r;
    int lat;
    conv_done = 1'b0;
    conv_row  = '0;
    forever begin
      @(negedge clk);
      if (conv_start === 1'b1 && reset === 1'b0) begin
        r   = unit_row % ROWS;
        lat = lat_tab[r];
        repeat (lat) @(posedge clk);
        #1;
        conv_done = 1'b1;
        for (int c = 0; c < COLS; c++) conv_row[c*DW +: DW] = gen[r][c];
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        unit_row++;
      end
    end
  end

  function automatic int first_bad(input logic [DW-1:0] m [ROWS][COLS]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (featureMap[(r*COLS+c)*DW +: DW] !== m[r][c]) return r*COLS + c;
    return -1;
  endfunction

  // Begin a pass in the current cycle (caller sits just after a rising edge)
  task automatic launch(input int mode, output int c0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++)
        gen[r][c] = (mode == 0) ? DW'(r*100 + c) : DW'($urandom);
    end
    cs_q.delete();
    row_q.delete();
    done_q.delete();
    busy_cnt = 0;
    unit_row = 0;
    start    = 1'b1;
    c0       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int d);
    bit found = 0;
    d = -1;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1;
        d = cyc;
      end
    end
    if (!found) begin
      tests++;
      failed++;
      $display("FAIL %s_done_timeout: got no done, required done within 2000 cycles", nm);
    end
  endtask

  // Full-pass checks: timeline from the latency table, rows, map, busy
  task automatic check_pass(input int c0, input int d, input string nm);
    int exp_start[ROWS];
    int t = 1;
    int bad;
    for (int r = 0; r < ROWS; r++) begin
      exp_start[r] = t;
      t += 1 + lat_tab[r];
    end
    tests++;
    if (cs_q.size() !== ROWS) begin
      failed++;
      $display("FAIL %s_pulse_count: got %0d required %0d", nm, cs_q.size(), ROWS);
    end
    bad = -1;
    for (int r = 0; r < ROWS && r < cs_q.size(); r++)
      if (bad < 0 && cs_q[r] - c0 !== exp_start[r]) bad = r;
    tests++;
    if (bad >= 0) begin
      failed++;
      $display("FAIL %s_start_cycle: row %0d got cycle %0d required %0d", nm, bad,
               cs_q[bad] - c0, exp_start[bad]);
    end
    bad = -1;
    for (int r = 0; r < ROWS && r < row_q.size(); r++)
      if (bad < 0 && row_q[r] !== r) bad = r;
    tests++;
    if (bad >= 0) begin
      failed++;
      $display("FAIL %s_row_seq: pulse %0d got row %0d required %0d", nm, bad, row_q[bad], bad);
    end
    tests++;
    if (done_q.size() !== 1 || d - c0 !== t) begin
      failed++;
      $display("FAIL %s_done_cycle: got cycle %0d (%0d pulses) required cycle %0d (1 pulse)",
               nm, d - c0, done_q.size(), t);
    end
    tests++;
    if (busy_cnt !== t) begin
      failed++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", nm, busy_cnt, t);
    end
    bad = first_bad(gen);
    tests++;
    if (bad >= 0) begin
      failed++;
      $display("FAIL %s_map: element %0d got %0h required %0h", nm, bad,
               featureMap[bad*DW +: DW], gen[bad/COLS][bad%COLS]);
    end
    exp_map = gen;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b1;
    conv_done = 1'b1;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rowNumber !== 6'd0 || conv_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got row=%0d cs=%b busy=%b done=%b required 0 0 0 0",
               rowNumber, conv_start, busy, done);
    end
    tests++;
    if (featureMap !== '0) begin
      failed++;
      $display("FAIL reset_map: got nonzero map required all zeros");
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    start     = 1'b0;
    conv_done = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || cs_q.size() !== 0) begin
      failed++;
      $display("FAIL reset_idle: got busy=%b pulses=%0d required busy=0 pulses=0", busy, cs_q.size());
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_map[r][c] = '0;
  endtask

  task automatic test_full_pass;
    int c0, d;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 3;
    @(posedge clk);
    #1;
    launch(0, c0);
    wait_done("full", d);
    check_pass(c0, d, "full");
    tests++;
    if (featureMap[(27*COLS+27)*DW +: DW] !== DW'(2727)) begin
      failed++;
      $display("FAIL full_elem_27_27: got %0d required 2727", featureMap[(27*COLS+27)*DW +: DW]);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL full_after_done: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_spurious;
    int c0, d, bad;
    logic [5:0] row_before;
    // conv_done while idle
    @(posedge clk);
    #1;
    row_before = rowNumber;
    conv_done  = 1'b1;
    conv_row   = {COLS{DW'($urandom)}};
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    @(negedge clk);
    bad = first_bad(exp_map);
    tests++;
    if (bad >= 0 || rowNumber !== row_before || busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_conv_done: got bad_elem=%0d row=%0d busy=%b required -1 %0d 0",
               bad, rowNumber, busy, row_before);
    end
    // conv_done in the ISSUE cycle, start during WAIT of row 5
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 3;
    @(posedge clk);
    #1;
    launch(1, c0);
    conv_done = 1'b1;
    conv_row  = {COLS{DW'($urandom)}};
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    @(negedge clk);
    bad = -1;
    for (int c = 0; c < COLS; c++)
      if (bad < 0 && featureMap[c*DW +: DW] !== exp_map[0][c]) bad = c;
    tests++;
    if (bad >= 0 || rowNumber !== 6'd0 || conv_start !== 1'b0) begin
      failed++;
      $display("FAIL issue_conv_done: got bad_col=%0d row=%0d cs=%b required -1 0 0",
               bad, rowNumber, conv_start);
    end
    @(posedge clk);
    #1;
    repeat (19) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("spur", d);
    check_pass(c0, d, "spur");
  endtask

  task automatic test_back_to_back;
    int c0a, c0b, d1, d2;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 1;
    @(posedge clk);
    #1;
    launch(1, c0a);
    wait_done("b2b1", d1);
    check_pass(c0a, d1, "b2b1");
    @(posedge clk);
    #1;
    launch(1, c0b);
    wait_done("b2b2", d2);
    check_pass(c0b, d2, "b2b2");
    tests++;
    if (cs_q.size() == 0 || cs_q[0] !== d1 + 2) begin
      failed++;
      $display("FAIL b2b_first_start: got cycle %0d required %0d",
               (cs_q.size() == 0) ? -1 : cs_q[0], d1 + 2);
    end
    tests++;
    if (d1 - c0a !== 57) begin
      failed++;
      $display("FAIL b2b_min_pass: got %0d required 57", d1 - c0a);
    end
  endtask

  task automatic test_mid_reset;
    int c0, d, bad;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 3;
    @(posedge clk);
    #1;
    launch(1, c0);
    repeat (44) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_map[r][c] = '0;
    bad = first_bad(exp_map);
    tests++;
    if (busy !== 1'b0 || rowNumber !== 6'd0 || bad >= 0) begin
      failed++;
      $display("FAIL midreset_state: got busy=%b row=%0d bad_elem=%0d required 0 0 -1",
               busy, rowNumber, bad);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (done_q.size() !== 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midreset_no_done: got %0d done pulses busy=%b required 0 0", done_q.size(), busy);
    end
    for (int r = 0; r < ROWS; r++) lat_tab[r] = 2;
    @(posedge clk);
    #1;
    launch(1, c0);
    wait_done("restart", d);
    check_pass(c0, d, "restart");
  endtask

  task automatic test_variable_latency;
    int c0, d;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = (r % 2 == 0) ? 1 : 7;
    @(posedge clk);
    #1;
    launch(1, c0);
    wait_done("varlat", d);
    check_pass(c0, d, "varlat");
    tests++;
    if (d - c0 !== 141) begin
      failed++;
      $display("FAIL varlat_done_141: got %0d required 141", d - c0);
    end
  endtask

  task automatic test_random_latency;
    int c0, d;
    for (int r = 0; r < ROWS; r++) lat_tab[r] = int'($urandom_range(1, 6));
    @(posedge clk);
    #1;
    launch(1, c0);
    wait_done("randlat", d);
    check_pass(c0, d, "randlat");
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    unit_row  = 0;
    busy_cnt  = 0;
    test_reset();
    test_full_pass();
    test_spurious();
    test_back_to_back();
    test_mid_reset();
    test_variable_latency();
    test_random_latency();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
